// File: rtl/uart_inst_loader.sv
// uart_inst_loader
//   Boot-time program loader. Receives 8N1 UART bytes on rx_i and packs each
//   group of four bytes (least-significant byte first) into one 32-bit word.
//   Each word is written to ICCM at sequential word addresses starting at 0.
//   The core is held in reset until en_i ends the load. Any pending write is
//   then drained and the core is released.
//
// Ports
//   clk_i, rst_i   : system clock, asynchronous active-high reset
//   rx_i           : UART serial input (idle high, asynchronous to clk_i)
//   en_i           : level, end of load / start core
//   mem_req_o      : ICCM write request; address and data stay stable until granted
//   mem_gnt_i      : write accepted in this cycle
//   mem_addr_o     : byte address of the write (bits [1:0] always 0)
//   mem_wdata_o    : write data
//   sys_rst_o      : core reset, high while loading
//   done_o         : loading finished
//   word_count_o   : number of words written so far
//   frame_err_o    : sticky, a stop bit was sampled low
//   overrun_o      : sticky, a word was dropped while a write was pending
//
// Handshake: a write transfers in any cycle where mem_req_o && mem_gnt_i.
// While mem_req_o is high and not granted, addr/data/req do not change.
module uart_inst_loader #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 14
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rx_i,
    input  logic                  en_i,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  sys_rst_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-3:0] word_count_o,
    output logic                  frame_err_o,
    output logic                  overrun_o
);
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int CNT_W = ADDR_WIDTH - 2;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {LD_LOAD, LD_DRAIN, LD_DONE} ld_state_t;

    logic                  rx_meta_q, rx_sync_q;
    rx_state_t             rx_state_q, rx_state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  byte_valid, stop_bad;

    ld_state_t             ld_state_q, ld_state_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           asm_q, asm_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
    logic                  sys_rst_q, sys_rst_d;
    logic                  done_q, done_d;

    logic in_load, accept_byte, word_done, grant;

    // Two-flop synchroniser; reset to idle-high so no false start after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    // RX bit-timing machine. byte_valid / stop_bad are single-cycle strobes in
    // the stop-sample cycle.
    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        stop_bad   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A start bit that is high again at mid-bit is a glitch.
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) rx_state_d = RX_STOP;
                    else               bit_d = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d      = '0;
                    rx_state_d = RX_IDLE;
                    byte_valid = rx_sync_q;
                    stop_bad   = !rx_sync_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign in_load     = (ld_state_q == LD_LOAD);
    assign accept_byte = byte_valid && in_load;
    assign word_done   = accept_byte && (byte_idx_q == 2'd3);
    assign grant       = req_q && mem_gnt_i;

    // Word assembly, write handshake and loader sequencing.
    always_comb begin
        ld_state_d  = ld_state_q;
        byte_idx_d  = byte_idx_q;
        asm_d       = asm_q;
        req_d       = req_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        count_d     = count_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        sys_rst_d   = (ld_state_q != LD_DONE);
        done_d      = (ld_state_q == LD_DONE);

        if (accept_byte) begin
            byte_idx_d = byte_idx_q + 2'd1;
            case (byte_idx_q)
                2'd0:    asm_d[7:0]   = shift_q;
                2'd1:    asm_d[15:8]  = shift_q;
                2'd2:    asm_d[23:16] = shift_q;
                default: ;
            endcase
        end
        if (stop_bad && in_load) frame_err_d = 1'b1;

        if (grant) begin
            req_d   = 1'b0;
            addr_d  = addr_q + ADDR_WIDTH'(4);
            count_d = count_q + CNT_W'(1);
        end
        // A word finishing in the grant cycle replaces the one leaving;
        // otherwise a still-pending write wins and the new word is lost.
        if (word_done) begin
            if (req_q && !mem_gnt_i) begin
                overrun_d = 1'b1;
            end else begin
                req_d   = 1'b1;
                wdata_d = {shift_q, asm_q};
            end
        end

        case (ld_state_q)
            LD_LOAD:  if (en_i) ld_state_d = LD_DRAIN;
            LD_DRAIN: begin
                byte_idx_d = '0;
                asm_d      = '0;
                if (!req_q) ld_state_d = LD_DONE;
            end
            default:  ld_state_d = LD_DONE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_state_q  <= RX_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            ld_state_q  <= LD_LOAD;
            byte_idx_q  <= '0;
            asm_q       <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            sys_rst_q   <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            ld_state_q  <= ld_state_d;
            byte_idx_q  <= byte_idx_d;
            asm_q       <= asm_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            sys_rst_q   <= sys_rst_d;
            done_q      <= done_d;
        end
    end

    assign mem_req_o    = req_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign word_count_o = count_q;
    assign frame_err_o  = frame_err_q;
    assign overrun_o    = overrun_q;
    assign sys_rst_o    = sys_rst_q;
    assign done_o       = done_q;
endmodule

// File: tb/tb_uart_inst_loader.sv
// Testbench for uart_inst_loader. Uses CLKS_PER_BIT = 8 and a 5-bit address
// so the address and word-count wrap can be reached in a short run.
module tb_uart_inst_loader;
    localparam int CPB = 8;
    localparam int AW  = 5;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          rx_i = 1'b1;
    logic          en_i = 1'b0;
    logic          mem_gnt_i = 1'b1;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic          sys_rst_o, done_o, frame_err_o, overrun_o;
    logic [AW-3:0] word_count_o;

    uart_inst_loader #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i), .en_i(en_i),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .sys_rst_o(sys_rst_o), .done_o(done_o),
        .word_count_o(word_count_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o)
    );

    // Clock / counters
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] word;
    } vec_t;
    vec_t tbl[8];

    logic [AW+31:0] exp_q[$];
    logic [AW-1:0]  exp_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rx_i = 1'b1; en_i = 1'b0; mem_gnt_i = 1'b1;
        rst_i = 1'b1;
        tick(3);
        rst_i = 1'b0;
        exp_q.delete();
        exp_addr = '0;
        tick(2);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            tick(CPB);
        end
        rx_i = stop_bit;
        tick(CPB);
        rx_i = 1'b1;
        tick(2 * CPB);
    endtask

    task automatic push_exp(input logic [31:0] w);
        exp_q.push_back({exp_addr, w});
        exp_addr = exp_addr + AW'(4);
    endtask

    task automatic send_vec(input int i, input bit expect_write);
        if (expect_write) push_exp(tbl[i].word);
        send_byte(tbl[i].b0);
        send_byte(tbl[i].b1);
        send_byte(tbl[i].b2);
        send_byte(tbl[i].b3);
    endtask

    task automatic wait_req(input int max_clks);
        int n = 0;
        while (!mem_req_o && n < max_clks) begin
            tick();
            n++;
        end
        check("req_wait", mem_req_o, 1);
    endtask

    // Scoreboard: every granted write must match the oldest expected entry.
    always @(negedge clk) begin
        logic [AW+31:0] e;
        if (!rst_i && mem_req_o && mem_gnt_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", mem_addr_o, e[AW+31:32]);
                check("wr_data", mem_wdata_o, e[31:0]);
            end
        end
    end

    initial begin
        int req_seen;
        int unstable;
        logic [AW-1:0] hold_addr;
        logic [31:0]   hold_data;

        tbl[0] = '{8'h13, 8'h01, 8'h20, 8'h00, 32'h00200113};
        tbl[1] = '{8'h93, 8'h02, 8'h40, 8'h00, 32'h00400293};
        tbl[2] = '{8'h23, 8'ha0, 8'h55, 8'h00, 32'h0055a023};
        tbl[3] = '{8'hef, 8'hbe, 8'had, 8'hde, 32'hdeadbeef};
        tbl[4] = '{8'h78, 8'h56, 8'h34, 8'h12, 32'h12345678};
        tbl[5] = '{8'hff, 8'h00, 8'hff, 8'h00, 32'h00ff00ff};
        tbl[6] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201};
        tbl[7] = '{8'haa, 8'h55, 8'haa, 8'h55, 32'h55aa55aa};

        // Reset values, then quiet line for 1000 clocks
        do_reset();
        check("rst_req", mem_req_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_wdata", mem_wdata_o, 0);
        check("rst_sys_rst", sys_rst_o, 1);
        check("rst_done", done_o, 0);
        check("rst_count", word_count_o, 0);
        check("rst_frame_err", frame_err_o, 0);
        check("rst_overrun", overrun_o, 0);
        req_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (mem_req_o) req_seen++;
        end
        check("idle_no_req", req_seen, 0);

        // Single word with grant tied high
        send_vec(0, 1'b1);
        tick(10);
        check("single_count", word_count_o, 1);
        check("single_req_low", mem_req_o, 0);
        check("single_q_empty", exp_q.size(), 0);

        // Stream with back-pressure
        do_reset();
        mem_gnt_i = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            send_vec(w, 1'b1);
            wait_req(100);
            hold_addr = mem_addr_o;
            hold_data = mem_wdata_o;
            unstable = 0;
            for (int c = 0; c < 20; c++) begin
                tick();
                if (!mem_req_o || mem_addr_o !== hold_addr || mem_wdata_o !== hold_data) unstable++;
            end
            check("bp_stable", unstable, 0);
            mem_gnt_i = 1'b1;
            tick();
            mem_gnt_i = 1'b0;
        end
        tick(5);
        check("bp_count", word_count_o, 3);
        check("bp_overrun", overrun_o, 0);
        check("bp_q_empty", exp_q.size(), 0);

        // Overrun: second word arrives while the first is still pending
        do_reset();
        mem_gnt_i = 1'b0;
        send_vec(3, 1'b1);
        send_vec(4, 1'b0);
        check("ovr_flag", overrun_o, 1);
        check("ovr_held_data", mem_wdata_o, 32'hdeadbeef);
        check("ovr_held_addr", mem_addr_o, 0);
        mem_gnt_i = 1'b1;
        tick(5);
        check("ovr_count", word_count_o, 1);
        check("ovr_req_low", mem_req_o, 0);
        check("ovr_q_empty", exp_q.size(), 0);

        // Framing error and start-bit glitch leave the byte index alone
        do_reset();
        push_exp(32'h55443311);
        send_byte(8'h11);
        send_byte(8'h22, 1'b0);
        check("frame_err", frame_err_o, 1);
        send_byte(8'h33);
        rx_i = 1'b0;
        tick(2);
        rx_i = 1'b1;
        tick(30);
        send_byte(8'h44);
        send_byte(8'h55);
        tick(10);
        check("fe_count", word_count_o, 1);
        check("fe_q_empty", exp_q.size(), 0);

        // Address and word-count wrap
        do_reset();
        for (int i = 0; i < 9; i++) send_vec(i % 8, 1'b1);
        tick(10);
        check("wrap_count", word_count_o, 1);
        check("wrap_addr", mem_addr_o, 4);
        check("wrap_q_empty", exp_q.size(), 0);

        // Finish: 5 words + 2 bytes + half a byte, then en_i
        do_reset();
        for (int i = 0; i < 5; i++) send_vec(i, 1'b1);
        send_byte(tbl[5].b0);
        send_byte(tbl[5].b1);
        rx_i = 1'b0;
        tick(3 * CPB);
        en_i = 1'b1;
        tick(CPB);
        rx_i = 1'b1;
        begin
            int n = 0;
            while (!done_o && n < 50) begin
                tick();
                n++;
            end
        end
        check("fin_done", done_o, 1);
        check("fin_sys_rst", sys_rst_o, 0);
        check("fin_count", word_count_o, 5);
        check("fin_q_empty", exp_q.size(), 0);
        send_vec(6, 1'b0);
        tick(10);
        check("fin_no_write_count", word_count_o, 5);
        check("fin_req_low", mem_req_o, 0);

        // Asynchronous reset in the middle of a byte
        rx_i = 1'b0;
        tick(20);
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_done", done_o, 0);
        check("arst_sys_rst", sys_rst_o, 1);
        check("arst_count", word_count_o, 0);
        check("arst_req", mem_req_o, 0);
        check("arst_frame_err", frame_err_o, 0);
        en_i = 1'b0;
        rx_i = 1'b1;
        tick(3);
        rst_i = 1'b0;
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_inst_loader.md
# uart_inst_loader

Boot-time program loader between the SoC's `uart_rx_inst` pin and the instruction memory write port. It receives 8N1 UART bytes and packs each four-byte group, least-significant byte first, into one 32-bit word. Each completed word is written to ICCM at sequential word-aligned addresses starting at 0. While loading is in progress, the loader holds the core in reset. When `en_i` arrives, it drains any pending write and releases the core.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 10417: clocks per UART bit (100 MHz / 9600 baud, rounded up); must be ≥ 4.
- `DATA_WIDTH`, default 32: word width; fixed at 32 (four bytes per word).
- `ADDR_WIDTH`, default 14: byte-address width of the ICCM write port.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i` input 1: system clock.
- `rst_i` input 1: asynchronous, active-high reset.
- `rx_i` input 1: UART serial input; idle high; asynchronous to `clk_i`.
- `en_i` input 1: level; end of load, start core.
- `mem_req_o` output 1: write request to ICCM.
- `mem_gnt_i` input 1: write accepted this cycle.
- `mem_addr_o` output ADDR_WIDTH: byte address of the write; bits [1:0] always 0.
- `mem_wdata_o` output 32: write data.
- `sys_rst_o` output 1: active-high core reset; high while loading.
- `done_o` output 1: loading finished.
- `word_count_o` output ADDR_WIDTH-2: number of words written so far.
- `frame_err_o` output 1: sticky; a stop bit was sampled low.
- `overrun_o` output 1: sticky; a word was dropped because the previous write was still pending.

## Operation
- Input synchronisation: `rx_i` passes through 2 flops before any use. All "sample" events below refer to the synchronised signal.
- RX state machine, states IDLE, START, DATA, STOP:
  - IDLE → START on a sampled low.
  - START: wait `CLKS_PER_BIT/2` clocks, then re-sample. Low → DATA. High → IDLE (glitch rejected, no byte).
  - DATA: sample every `CLKS_PER_BIT` clocks, 8 bits, LSB first.
  - STOP: after `CLKS_PER_BIT` clocks, sample once.
    - High: the byte is valid; pulse byte-valid internally.
    - Low: set `frame_err_o`, discard the byte.
    - Either way, return to IDLE.
- Word assembly: 2-bit byte index, starting at 0.
  - Byte k is placed in `wdata[8k+7:8k]`.
  - On k = 3, the word is complete and the index wraps to 0.
- Write handshake:
  - A completed word loads the holding register and asserts `mem_req_o`.
  - `mem_req_o`, `mem_addr_o` and `mem_wdata_o` stay stable until a cycle where `mem_req_o && mem_gnt_i`.
  - On that grant cycle: address += 4 (wraps modulo 2^ADDR_WIDTH) and `word_count_o` += 1. `mem_req_o` deasserts next cycle unless a new word completes in the same cycle (see boundary cases).
- Loader FSM, states LOAD, DRAIN, DONE:
  - LOAD: accept bytes. `en_i` high → DRAIN.
  - DRAIN: the RX machine is ignored and any partial word is discarded. Once no write is pending → DONE.
  - DONE: terminal until reset. `sys_rst_o` = 0, `done_o` = 1, no further requests.
- Boundary cases:
  - A word completes while a write is pending and ungranted: set `overrun_o`, drop the new word; the pending write is unchanged.
  - A word completes in the same cycle as the grant: the new word is accepted. `mem_req_o` stays high with the next address and the new data.
  - Address wrap: 0x3FFC + 4 → 0x0000; the word counter wraps likewise.
  - `en_i` asserted mid-byte: the byte and the partial word are discarded.
  - `rst_i` mid-operation: all state is cleared immediately, including sticky flags and the partially received byte.

## Timing
- Reset values: `mem_req_o` 0, `mem_addr_o` 0, `mem_wdata_o` 0, `sys_rst_o` 1, `done_o` 0, `word_count_o` 0, `frame_err_o` 0, `overrun_o` 0.
- A falling edge on `rx_i` is seen by the FSM 2 clocks later.
- Byte valid occurs `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` clocks after the synchronised start edge, ±1.
- `mem_req_o` rises 1 clock after the 4th byte-valid.
- The write completes in the grant cycle. With `mem_gnt_i` tied high, `mem_req_o` is a one-cycle pulse.
- `sys_rst_o` falls and `done_o` rises 1 clock after entry to DONE.
- `frame_err_o` sets 1 clock after the bad stop sample.
- `overrun_o` sets 1 clock after the dropped word completes.

## Test plan
Benches use `CLKS_PER_BIT` = 8 unless noted.
- Reset: `rst_i` pulse, `rx_i` idle high → all outputs at their reset values; no `mem_req_o` for 1000 clocks.
- Single word: send bytes 0x13, 0x01, 0x20, 0x00 with `mem_gnt_i` = 1 → one write, `mem_addr_o` = 0x0, `mem_wdata_o` = 0x00200113, `word_count_o` = 1.
- Stream with back-pressure: 3 words, `mem_gnt_i` low for 20 clocks each time → writes land at 0x0/0x4/0x8 in order, data stable while waiting, `overrun_o` stays 0.
- Overrun: hold `mem_gnt_i` low across 2 complete words → first word preserved, `overrun_o` = 1, `word_count_o` = 1 after the grant.
- Framing and glitch:
  - A byte with stop bit 0 → `frame_err_o` = 1, byte index unchanged.
  - A 2-clock low glitch → no byte produced.
- Finish: after 5 words plus 2 bytes, assert `en_i` → partial bytes discarded, `word_count_o` = 5, `sys_rst_o` falls, `done_o` = 1. Later `rx_i` traffic produces no writes. Apply async `rst_i` mid-byte → immediate return to reset values.
